cpu_ctrl_fsm: RTL

Main control state machine for the next-generation Simple RISC Machine core. It sequences instruction fetch, decode, execute and writeback for the full instruction set: MOV, ALU, LDR, STR, B<cond>, BL, BX and HALT. It drives the register-file and datapath control lines, the PC and address-register loads, and the memory command bus. Memory access uses a ready handshake with a configurable timeout that traps into a FAULT state.

---
 rtl/cpu_ctrl_pkg.sv | 54 +++++
 rtl/cpu_ctrl_cond.sv | 30 +++
 rtl/cpu_ctrl_fsm.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the Simple RISC Machine control FSM:
// state codes, instruction fields and datapath select values.
package cpu_ctrl_pkg;

   typedef enum logic [4:0] {
      S_RST   = 5'd0,
      S_IF1, S_IF2, S_UPC, S_DEC,
      S_WIMM, S_GETA, S_GETB, S_EXEC, S_EXECM, S_WREG, S_CMP,
      S_ADDR, S_LADR, S_MRD, S_LDWB, S_GETD, S_SOUT, S_MWR,
      S_BR, S_LINK, S_BXR, S_BXC, S_BXPC,
      S_HALT, S_FAULT
   } state_t;

   localparam logic [2:0] OPC_BR   = 3'b001;
   localparam logic [2:0] OPC_BLX  = 3'b010;
   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_CMP  = 2'b01;
   localparam logic [1:0] OP_AND  = 2'b10;
   localparam logic [1:0] OP_MVN  = 2'b11;
   localparam logic [1:0] OP_MOVR = 2'b00;
   localparam logic [1:0] OP_MOVI = 2'b10;
   localparam logic [1:0] OP_MEM  = 2'b00;
   localparam logic [1:0] OP_B    = 2'b00;
   localparam logic [1:0] OP_BX   = 2'b00;
   localparam logic [1:0] OP_BL   = 2'b11;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_PC    = 2'b01;
   localparam logic [1:0] VSEL_IMM   = 2'b10;
   localparam logic [1:0] VSEL_MDATA = 2'b11;

   localparam logic [1:0] PCSEL_INC = 2'b00;
   localparam logic [1:0] PCSEL_REL = 2'b01;
   localparam logic [1:0] PCSEL_REG = 2'b10;

   localparam logic [1:0] NSEL_RN = 2'b00;
   localparam logic [1:0] NSEL_RD = 2'b01;
   localparam logic [1:0] NSEL_RM = 2'b10;

   function automatic logic is_mem_wait(input state_t s);
      return (s == S_IF1) || (s == S_MRD) || (s == S_MWR);
   endfunction

endpackage

// File: rtl/cpu_ctrl_cond.sv
// Branch condition evaluator: decides taken/illegal from cond and {N,V,Z}.
module cpu_ctrl_cond
   import cpu_ctrl_pkg::*;
(
   input  logic [2:0] i_cond,
   input  logic [2:0] i_status,
   output logic       o_taken,
   output logic       o_illegal
);

   logic w_n, w_v, w_z;

   assign w_n = i_status[2];
   assign w_v = i_status[1];
   assign w_z = i_status[0];

   always_comb begin
      o_taken   = 1'b0;
      o_illegal = 1'b0;
      case (i_cond)
         3'b000:  o_taken = 1'b1;
         3'b001:  o_taken = w_z;
         3'b010:  o_taken = ~w_z;
         3'b011:  o_taken = w_n ^ w_v;
         3'b100:  o_taken = (w_n ^ w_v) | w_z;
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Moore control FSM: fetch/decode/execute/writeback sequencing with
// memory ready handshake and a per-wait-state timeout into FAULT.
module cpu_ctrl_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int STATE_W     = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         opcode,
   input  logic [1:0]         op,
   input  logic [2:0]         cond,
   input  logic [2:0]         status,
   input  logic               mem_ready,
   output logic [1:0]         nsel,
   output logic               loada,
   output logic               loadb,
   output logic               loadc,
   output logic               loads,
   output logic               asel,
   output logic               bsel,
   output logic               write,
   output logic [1:0]         vsel,
   output logic               load_pc,
   output logic               reset_pc,
   output logic               load_ir,
   output logic               load_addr,
   output logic               addr_sel,
   output logic [1:0]         pc_sel,
   output logic [1:0]         mem_cmd,
   output logic               halted,
   output logic               fault,
   output logic [STATE_W-1:0] state
);

   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             w_taken, w_illegal, w_timeout;
   logic [4:0]       w_instr;

   cpu_ctrl_cond u_cond (
      .i_cond    (cond),
      .i_status  (status),
      .o_taken   (w_taken),
      .o_illegal (w_illegal)
   );

   assign w_instr   = {opcode, op};
   assign w_timeout = (MEM_TIMEOUT != 0) && !mem_ready &&
                      (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
   assign state     = STATE_W'(r_state);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_RST;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_cnt <= '0;
         else if (MEM_TIMEOUT != 0 && is_mem_wait(r_state) && !mem_ready)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_next    = r_state;
      nsel      = NSEL_RN;
      loada     = 1'b0;
      loadb     = 1'b0;
      loadc     = 1'b0;
      loads     = 1'b0;
      asel      = 1'b0;
      bsel      = 1'b0;
      write     = 1'b0;
      vsel      = VSEL_C;
      load_pc   = 1'b0;
      reset_pc  = 1'b0;
      load_ir   = 1'b0;
      load_addr = 1'b0;
      addr_sel  = 1'b0;
      pc_sel    = PCSEL_INC;
      mem_cmd   = MEM_NONE;
      halted    = 1'b0;
      fault     = 1'b0;
      case (r_state)
         S_RST: begin
            reset_pc = 1'b1;
            load_pc  = 1'b1;
            w_next   = S_IF1;
         end
         S_IF1: begin
            addr_sel = 1'b1;
            mem_cmd  = MEM_READ;
            if (mem_ready)      w_next = S_IF2;
            else if (w_timeout) w_next = S_FAULT;
         end
         S_IF2: begin
            addr_sel = 1'b1;
            mem_cmd  = MEM_READ;
            load_ir  = 1'b1;
            w_next   = S_UPC;
         end
         S_UPC: begin
            load_pc = 1'b1;
            pc_sel  = PCSEL_INC;
            w_next  = S_DEC;
         end
         S_DEC: begin
            casez (w_instr)
               {OPC_MOV, OP_MOVI}:                     w_next = S_WIMM;
               {OPC_MOV, OP_MOVR}, {OPC_ALU, OP_MVN}:  w_next = S_GETB;
               {OPC_ALU, OP_ADD}, {OPC_ALU, OP_AND},
               {OPC_ALU, OP_CMP}, {OPC_LDR, OP_MEM},
               {OPC_STR, OP_MEM}:                      w_next = S_GETA;
               {OPC_BR, OP_B}: begin
                  if (w_illegal)    w_next = S_FAULT;
                  else if (w_taken) w_next = S_BR;
                  else              w_next = S_IF1;
               end
               {OPC_BLX, OP_BL}:                       w_next = S_LINK;
               {OPC_BLX, OP_BX}:                       w_next = S_BXR;
               5'b111??:                               w_next = S_HALT;
               default:                                w_next = S_FAULT;
            endcase
         end
         S_WIMM: begin
            nsel   = NSEL_RN;
            vsel   = VSEL_IMM;
            write  = 1'b1;
            w_next = S_IF1;
         end
         S_GETA: begin
            nsel   = NSEL_RN;
            loada  = 1'b1;
            w_next = (opcode == OPC_LDR || opcode == OPC_STR) ? S_ADDR : S_GETB;
         end
         S_GETB: begin
            nsel  = NSEL_RM;
            loadb = 1'b1;
            // EXECM is the asel=1 flavour of EXEC so asel stays a pure state decode
            if (opcode == OPC_ALU && op == OP_CMP)      w_next = S_CMP;
            else if (opcode == OPC_ALU && op != OP_MVN) w_next = S_EXEC;
            else                                        w_next = S_EXECM;
         end
         S_EXEC: begin
            loadc  = 1'b1;
            w_next = S_WREG;
         end
         S_EXECM: begin
            asel   = 1'b1;
            loadc  = 1'b1;
            w_next = S_WREG;
         end
         S_WREG: begin
            nsel   = NSEL_RD;
            vsel   = VSEL_C;
            write  = 1'b1;
            w_next = S_IF1;
         end
         S_CMP: begin
            loads  = 1'b1;
            w_next = S_IF1;
         end
         S_ADDR: begin
            bsel   = 1'b1;
            loadc  = 1'b1;
            w_next = S_LADR;
         end
         S_LADR: begin
            load_addr = 1'b1;
            w_next    = (opcode == OPC_STR) ? S_GETD : S_MRD;
         end
         S_MRD: begin
            mem_cmd = MEM_READ;
            if (mem_ready)      w_next = S_LDWB;
            else if (w_timeout) w_next = S_FAULT;
         end
         S_LDWB: begin
            mem_cmd = MEM_READ;
            nsel    = NSEL_RD;
            vsel    = VSEL_MDATA;
            write   = 1'b1;
            w_next  = S_IF1;
         end
         S_GETD: begin
            nsel   = NSEL_RD;
            loadb  = 1'b1;
            w_next = S_SOUT;
         end
         S_SOUT: begin
            asel   = 1'b1;
            loadc  = 1'b1;
            w_next = S_MWR;
         end
         S_MWR: begin
            mem_cmd = MEM_WRITE;
            if (mem_ready)      w_next = S_IF1;
            else if (w_timeout) w_next = S_FAULT;
         end
         S_BR: begin
            load_pc = 1'b1;
            pc_sel  = PCSEL_REL;
            w_next  = S_IF1;
         end
         S_LINK: begin
            nsel   = NSEL_RN;
            vsel   = VSEL_PC;
            write  = 1'b1;
            w_next = S_BR;
         end
         S_BXR: begin
            nsel   = NSEL_RD;
            loadb  = 1'b1;
            w_next = S_BXC;
         end
         S_BXC: begin
            asel   = 1'b1;
            loadc  = 1'b1;
            w_next = S_BXPC;
         end
         S_BXPC: begin
            load_pc = 1'b1;
            pc_sel  = PCSEL_REG;
            w_next  = S_IF1;
         end
         S_HALT:  halted = 1'b1;
         S_FAULT: fault  = 1'b1;
         default: w_next = S_FAULT;
      endcase
   end

endmodule
